// File: rtl/led_fade_driver.sv
// led_fade_driver
//   Drives eight board LEDs from the one-hot chaser pattern. A lit input bit
//   shows full on. When the bit is released, that LED fades out through a
//   decaying PWM duty, which gives the trailing "comet" effect.
//
//   Ports:
//     clk      system clock
//     reset    asynchronous, active-low reset (clears every flop at once)
//     led_in   [7:0] pattern from the chaser; bit i high = LED i lit
//     led_out  [7:0] registered PWM drive; bit i high = LED i on
//
//   Parameters:
//     PWM_BITS    width of the PWM counter and of each brightness level
//     DECAY_DIV   clk cycles between decay ticks (>= 1)
//     DECAY_STEP  amount removed from each unlit level per decay tick
//
//   Optional build macro:
//     LED_GAMMA_EN  when defined, the PWM compare uses a squared (perceptual)
//                   level, (level*level) >> PWM_BITS, instead of the linear
//                   level.
module led_fade_driver #(
  parameter int PWM_BITS   = 8,
  parameter int DECAY_DIV  = 390625,
  parameter int DECAY_STEP = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] led_in,
  output logic [7:0] led_out
);

  // The prescaler needs at least one bit, even when DECAY_DIV is 1.
  localparam int PRE_W = (DECAY_DIV > 1) ? $clog2(DECAY_DIV) : 1;

  localparam logic [PWM_BITS-1:0] FULL_LEVEL = {PWM_BITS{1'b1}};
  localparam logic [PWM_BITS-1:0] STEP       = PWM_BITS'(DECAY_STEP);
  localparam logic [PRE_W-1:0]    PRE_LAST   = PRE_W'(DECAY_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_r;
  logic [PRE_W-1:0]    prescaler_r;
  logic                decay_tick_s;
  logic [PWM_BITS-1:0] level_r     [8];
  logic [PWM_BITS-1:0] level_nxt_s [8];
  logic [7:0]          led_nxt_s;

  // Saturating decrement: the level stops at zero and never wraps to full.
  function automatic logic [PWM_BITS-1:0] decay_level(input logic [PWM_BITS-1:0] lvl);
    logic [PWM_BITS-1:0] res;
    if (lvl > STEP) begin
      res = lvl - STEP;
    end else begin
      res = {PWM_BITS{1'b0}};
    end
    return res;
  endfunction

`ifdef LED_GAMMA_EN
  // Perceptual level: square the level in a double-width product and keep
  // the top half. This is combinational, so output latency is unchanged.
  function automatic logic [PWM_BITS-1:0] perceived(input logic [PWM_BITS-1:0] lvl);
    logic [2*PWM_BITS-1:0] sq;
    sq = {{PWM_BITS{1'b0}}, lvl} * {{PWM_BITS{1'b0}}, lvl};
    return sq[2*PWM_BITS-1:PWM_BITS];
  endfunction
`else
  // Linear compare: the level is used as the duty directly.
  function automatic logic [PWM_BITS-1:0] perceived(input logic [PWM_BITS-1:0] lvl);
    return lvl;
  endfunction
`endif

  // Decay tick, next brightness levels and next LED drive.
  always_comb begin
    decay_tick_s = (prescaler_r == PRE_LAST);
    led_nxt_s    = 8'h00;
    for (int i = 0; i < 8; i++) begin
      level_nxt_s[i] = level_r[i];
      // A lit input reloads full scale, even on a decay tick.
      if (led_in[i]) begin
        level_nxt_s[i] = FULL_LEVEL;
      end else if (decay_tick_s) begin
        level_nxt_s[i] = decay_level(level_r[i]);
      end else begin
        level_nxt_s[i] = level_r[i];
      end
      // The compare uses the pre-edge level and counter, so level L gives
      // L high cycles per PWM period.
      led_nxt_s[i] = led_in[i] | (perceived(level_r[i]) > pwm_cnt_r);
    end
  end

  // PWM counter, decay prescaler, brightness levels and registered outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_cnt_r   <= {PWM_BITS{1'b0}};
      prescaler_r <= {PRE_W{1'b0}};
      for (int i = 0; i < 8; i++) begin
        level_r[i] <= {PWM_BITS{1'b0}};
      end
      led_out     <= 8'h00;
    end else begin
      pwm_cnt_r <= pwm_cnt_r + PWM_BITS'(1'b1);
      if (decay_tick_s) begin
        prescaler_r <= {PRE_W{1'b0}};
      end else begin
        prescaler_r <= prescaler_r + PRE_W'(1'b1);
      end
      for (int i = 0; i < 8; i++) begin
        level_r[i] <= level_nxt_s[i];
      end
      led_out <= led_nxt_s;
    end
  end

endmodule
